// File: rtl/bnn_weight_streamer.sv
// Host-side transmitter for the BNN weight-load nibble protocol: buffers one byte per
// neuron and streams each as low/high nibble beats. Optional macro: STREAM_GAP_EN.
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = 12,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             start,
  input  logic             stall,
  output logic [3:0]       nib_out,
  output logic             load_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_LO,
    SEND_HI,
`ifdef STREAM_GAP_EN
    GAP,
`endif
    FINISH
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       weight_mem [NUM_NEURONS];
  logic             wr_hit;

  // Writes are refused for the whole stream so the core sees the snapshot taken at start.
  assign wr_ready = ~busy;
  assign wr_hit   = wr_valid && wr_ready && (32'(wr_idx) < NUM_NEURONS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      nib_out <= '0;
      load_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      // NOTE: the buffer is small and must read back 0x00 after reset, so it is flops, not RAM.
      for (int i = 0; i < NUM_NEURONS; i++) weight_mem[i] <= '0;
    end else begin
      done <= 1'b0;
      if (wr_hit) weight_mem[wr_idx] <= wr_data;

      case (state)
        IDLE: begin
          load_en <= 1'b0;
          if (start) begin
            state <= SEND_LO;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end

        SEND_LO: begin
          if (stall) begin
            load_en <= 1'b0;
          end else begin
            nib_out <= weight_mem[idx][3:0];
            load_en <= 1'b1;
            state   <= SEND_HI;
          end
        end

        SEND_HI: begin
          if (stall) begin
            load_en <= 1'b0;
          end else begin
            nib_out <= weight_mem[idx][7:4];
            load_en <= 1'b1;
            if (idx == LAST_IDX) begin
              state <= FINISH;
            end else begin
              idx   <= idx + 1'b1;
`ifdef STREAM_GAP_EN
              state <= GAP;
`else
              state <= SEND_LO;
`endif
            end
          end
        end

`ifdef STREAM_GAP_EN
        GAP: begin
          load_en <= 1'b0;
          state   <= SEND_LO;
        end
`endif

        FINISH: begin
          load_en <= 1'b0;
          nib_out <= '0;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= IDLE;
        end

        default: begin
          load_en <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Randomized self-checking bench: a byte-array model of the buffer and a receiver model of
// the core rebuild weights from observed beats; stream timing is derived from neuron count.
module tb_bnn_weight_streamer;
  localparam int N     = 12;
  localparam int IDX_W = 4;
`ifdef STREAM_GAP_EN
  localparam int GAP_CYC = N - 1;
`else
  localparam int GAP_CYC = 0;
`endif

  logic             clk = 1'b0;
  logic             reset, wr_valid, start, stall;
  logic             wr_ready, load_en, busy, done;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_data;
  logic [3:0]       nib_out;

  bnn_weight_streamer #(.NUM_NEURONS(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_data(wr_data), .start(start), .stall(stall), .nib_out(nib_out),
    .load_en(load_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] model [N];
  logic [3:0] beats [$];
  int done_edge, first_edge, lows, stall_edges;

  // stream controls
  int stall_at, stall_len;
  bit rand_stall, poke_busy, reset_at7;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic write_byte(input int idx, input logic [7:0] data);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_idx   = IDX_W'(idx);
    wr_data  = data;
    if (idx < N) model[idx] = data;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Drives one stream and records beats at the falling edge; edges are counted from the
  // edge that samples start (edge 0).
  task automatic run_stream();
    int edges, cnt;
    bit poked;
    beats.delete();
    edges = -1; cnt = 0; lows = 0; stall_edges = 0; first_edge = -1; done_edge = -1;
    poked = 1'b0;
    @(negedge clk);
    start = 1'b1;
    while (1) begin
      @(negedge clk);
      edges++;
      start    = 1'b0;
      wr_valid = 1'b0;
      if (edges > 400) begin
        check("stream_timeout", edges, 0);
        break;
      end
      if (done) begin
        done_edge = edges;
        break;
      end
      if (load_en) begin
        beats.push_back(nib_out);
        if (first_edge < 0) first_edge = edges;
      end else if (beats.size() > 0) begin
        lows++;
      end
      if (reset_at7 && beats.size() == 7) begin
        reset = 1'b1;
        break;
      end
      if (poke_busy && !poked && beats.size() == 3) begin
        poked = 1'b1;
        check("wr_ready_busy", wr_ready, 0);
        check("busy_mid", busy, 1);
        start    = 1'b1;
        wr_valid = 1'b1;
        wr_idx   = '0;
        wr_data  = ~model[0];
      end
      if (rand_stall) begin
        stall = ($urandom_range(0, 3) == 0);
      end else if (beats.size() == stall_at && cnt < stall_len) begin
        stall = 1'b1;
        cnt++;
      end else begin
        stall = 1'b0;
      end
      if (stall) stall_edges++;
    end
    stall = 1'b0;
  endtask

  // Core receiver model: beat 2k is neuron k's low nibble, beat 2k+1 its high nibble.
  task automatic check_beats(input string tag);
    logic [7:0] rx [N];
    check({tag, "_beat_count"}, beats.size(), 2 * N);
    for (int k = 0; k < N; k++) rx[k] = 8'h00;
    for (int b = 0; b < beats.size() && b < 2 * N; b++) begin
      if (b % 2 == 0) rx[b / 2][3:0] = beats[b];
      else            rx[b / 2][7:4] = beats[b];
    end
    for (int k = 0; k < N; k++) check($sformatf("%s_w%0d", tag, k), rx[k], model[k]);
    check({tag, "_load_state"}, beats.size() / 2, N);
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_idx = '0; wr_data = '0; start = 1'b0; stall = 1'b0;
    stall_at = -1; stall_len = 0; rand_stall = 0; poke_busy = 0; reset_at7 = 0;
    for (int k = 0; k < N; k++) model[k] = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_nib", nib_out, 0);
    check("rst_load_en", load_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_ready", wr_ready, 1);

    // Two known bytes, nominal latency.
    write_byte(0, 8'hA5);
    write_byte(11, 8'h3C);
    run_stream();
    check("t1_first_beat_edge", first_edge, 1);
    check("t1_beat0", beats[0], 4'h5);
    check("t1_beat1", beats[1], 4'hA);
    check("t1_beat22", beats[22], 4'hC);
    check("t1_beat23", beats[23], 4'h3);
    check("t1_done_edge", done_edge, 2 * N + 1 + GAP_CYC);
    check("t1_lows", lows, GAP_CYC);
    check_beats("t1");
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // Counting pattern through the receiver model.
    for (int k = 0; k < N; k++) write_byte(k, 8'(k));
    run_stream();
    check_beats("t2");

    // Three-cycle stall after the fifth beat.
    for (int k = 0; k < N; k++) write_byte(k, 8'($urandom));
    stall_at = 5; stall_len = 3;
    run_stream();
    stall_at = -1;
    check("t3_lows", lows, 3 + GAP_CYC);
    check("t3_done_edge", done_edge, 2 * N + 1 + GAP_CYC + 3);
    check_beats("t3");

    // start/write while busy must be ignored.
    poke_busy = 1;
    run_stream();
    poke_busy = 0;
    check_beats("t4");
    repeat (3) @(negedge clk);
    check("t4_no_restart_busy", busy, 0);
    check("t4_no_restart_le", load_en, 0);

    // Out-of-range write.
    write_byte(12, 8'hFF);
    write_byte(15, 8'hFF);
    run_stream();
    check_beats("t5");

    // Random contents with random stalls.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 1)) write_byte(k, 8'($urandom));
      rand_stall = 1;
      run_stream();
      rand_stall = 0;
      check_beats($sformatf("rnd%0d", r));
    end

    // Reset after beat 7 aborts and clears the buffer.
    reset_at7 = 1;
    run_stream();
    reset_at7 = 0;
    check("t6_reached_beat7", beats.size(), 7);
    @(negedge clk);
    reset = 1'b0;
    check("t6_load_en", load_en, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    for (int k = 0; k < N; k++) model[k] = 8'h00;
    run_stream();
    check_beats("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
